// File: rtl/dequantizer_array.sv
// Dequantizer lane array: per-lane (ins * scale) <<< shift, saturated to the
// accumulator width, through a two-stage valid/ready pipeline with a saturation counter.
module dequantizer_array #(
  parameter int DEQUANT_SIZE           = 64,
  parameter int COMPUTE_DATA_WIDTH     = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int SCALE_WIDTH            = 8,
  parameter int SHIFT_WIDTH            = 4
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [DEQUANT_SIZE*COMPUTE_DATA_WIDTH-1:0]         ins,
  input  logic [SCALE_WIDTH-1:0]                             scale,
  input  logic [SHIFT_WIDTH-1:0]                             shift,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [DEQUANT_SIZE*ACCUMULATOR_DATA_WIDTH-1:0]     results,
  output logic                                               sat_any,
  input  logic                                               clr_sat,
  output logic [15:0]                                        sat_count
);

  localparam int N  = DEQUANT_SIZE;
  localparam int CW = COMPUTE_DATA_WIDTH;
  localparam int AW = ACCUMULATOR_DATA_WIDTH;
  localparam int PW = COMPUTE_DATA_WIDTH + SCALE_WIDTH;
  localparam int XW = PW + (1 << SHIFT_WIDTH) - 1;

  // Exact signed product; both operands are widened to the full product width first.
  function automatic logic signed [PW-1:0] mul_lane(input logic signed [CW-1:0] a,
                                                    input logic signed [SCALE_WIDTH-1:0] b);
    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    a_x = PW'(a);
    b_x = PW'(b);
    return a_x * b_x;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [AW:0] saturate(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] max_v;
    logic signed [XW-1:0] min_v;
    max_v = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    min_v = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};
    if (v > max_v)      return {1'b1, 1'b0, {(AW-1){1'b1}}};
    else if (v < min_v) return {1'b1, 1'b1, {(AW-1){1'b0}}};
    else                return {1'b0, v[AW-1:0]};
  endfunction

  logic                   vld_p1_q, vld_p1_d;
  logic [N*PW-1:0]        prod_p1_q, prod_p1_d;
  logic [SHIFT_WIDTH-1:0] shift_p1_q, shift_p1_d;
  logic                   vld_p2_q, vld_p2_d;
  logic [N*AW-1:0]        res_p2_q, res_p2_d;
  logic                   sat_p2_q, sat_p2_d;
  logic [15:0]            sat_count_q, sat_count_d;

  logic                   in_acc;
  logic                   s2_take;
  logic signed [XW-1:0]   lane_x;
  logic [AW:0]            lane_s;
  logic [N*AW-1:0]        res_w;
  logic                   sat_w;

  always_comb begin
    s2_take  = vld_p1_q && (!vld_p2_q || out_ready);
    in_ready = !vld_p1_q || !vld_p2_q || out_ready;
    in_acc   = in_valid && in_ready;
  end

  // Stage 1: lane products and the shift captured with the beat
  always_comb begin
    vld_p1_d   = vld_p1_q;
    prod_p1_d  = prod_p1_q;
    shift_p1_d = shift_p1_q;
    if (in_acc) begin
      vld_p1_d   = 1'b1;
      shift_p1_d = shift;
      for (int i = 0; i < N; i++) begin
        prod_p1_d[i*PW +: PW] = mul_lane(ins[i*CW +: CW], scale);
      end
    end else if (s2_take) begin
      vld_p1_d = 1'b0;
    end
  end

  // Stage 2: shift at full width, then clamp each lane
  always_comb begin
    lane_x = '0;
    lane_s = '0;
    res_w  = '0;
    sat_w  = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_x = XW'($signed(prod_p1_q[i*PW +: PW])) <<< shift_p1_q;
      lane_s = saturate(lane_x);
      res_w[i*AW +: AW] = lane_s[AW-1:0];
      sat_w  = sat_w | lane_s[AW];
    end
  end

  always_comb begin
    vld_p2_d = vld_p2_q;
    res_p2_d = res_p2_q;
    sat_p2_d = sat_p2_q;
    if (s2_take) begin
      vld_p2_d = 1'b1;
      res_p2_d = res_w;
      sat_p2_d = sat_w;
    end else if (out_ready) begin
      vld_p2_d = 1'b0;
    end
  end

  // Clear beats a simultaneous increment; the count sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (clr_sat)
      sat_count_d = '0;
    else if (vld_p2_q && out_ready && sat_p2_q && (sat_count_q != 16'hFFFF))
      sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      prod_p1_q   <= '0;
      shift_p1_q  <= '0;
      vld_p2_q    <= 1'b0;
      res_p2_q    <= '0;
      sat_p2_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      prod_p1_q   <= prod_p1_d;
      shift_p1_q  <= shift_p1_d;
      vld_p2_q    <= vld_p2_d;
      res_p2_q    <= res_p2_d;
      sat_p2_q    <= sat_p2_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign results   = res_p2_q;
  assign sat_any   = sat_p2_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_dequantizer_array.sv
// Bench for dequantizer_array: arithmetic reference model with an in-order queue,
// a per-cycle compare process, and directed vectors with hand-computed values.
module tb_dequantizer_array;
  localparam int N   = 64;
  localparam int CW  = 4;
  localparam int AW  = 16;
  localparam int SW  = 8;
  localparam int SHW = 4;
  localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW-1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*CW-1:0]   ins = '0;
  logic [SW-1:0]     scale = '0;
  logic [SHW-1:0]    shift = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N*AW-1:0]   results;
  logic              sat_any;
  logic              clr_sat = 1'b0;
  logic [15:0]       sat_count;

  int n_err = 0;
  int n_chk = 0;

  dequantizer_array dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .scale(scale), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .results(results), .sat_any(sat_any),
    .clr_sat(clr_sat), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*AW-1:0] res;
    logic            sat;
  } beat_t;

  beat_t      exp_q[$];
  logic [15:0] cnt_m = '0;
  logic        prev_stall = 1'b0;
  logic [N*AW-1:0] prev_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      for (int i = 0; i < N; i++) begin
        if (act[i*AW +: AW] !== exp[i*AW +: AW]) begin
          $display("FAIL %s: lane %0d got %0h expected %0h", nm, i, act[i*AW +: AW], exp[i*AW +: AW]);
          break;
        end
      end
    end
  endtask

  function automatic beat_t model(input logic [N*CW-1:0] iv, input logic [SW-1:0] sc,
                                  input logic [SHW-1:0] sh);
    beat_t  b;
    longint s;
    longint a;
    longint v;
    b.res = '0;
    b.sat = 1'b0;
    s = longint'($signed(sc));
    for (int i = 0; i < N; i++) begin
      a = longint'($signed(iv[i*CW +: CW]));
      v = a * s * (longint'(1) << sh);
      if (v > MAXV) begin v = MAXV; b.sat = 1'b1; end
      else if (v < MINV) begin v = MINV; b.sat = 1'b1; end
      b.res[i*AW +: AW] = v[AW-1:0];
    end
    return b;
  endfunction

  function automatic logic [N*CW-1:0] rep_ins(input logic [CW-1:0] v);
    logic [N*CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = v;
    return r;
  endfunction

  function automatic logic [N*AW-1:0] rep_res(input logic [AW-1:0] v);
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  // Compare process: everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cnt_m      = '0;
      prev_stall = 1'b0;
    end else begin
      chk("mon_sat_count", 32'(sat_count), 32'(cnt_m));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          chk_res("mon_results", results, exp_q[0].res);
          chk("mon_sat_any", 32'(sat_any), 32'(exp_q[0].sat));
        end
        if (prev_stall) chk_res("mon_stall_hold", results, prev_res);
      end else if (prev_stall) begin
        chk("mon_valid_dropped", 32'(out_valid), 32'd1);
      end
      if (clr_sat) cnt_m = '0;
      else if (out_valid && out_ready && exp_q.size() > 0 && exp_q[0].sat && cnt_m != 16'hFFFF)
        cnt_m = cnt_m + 16'd1;
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_stall = out_valid && !out_ready;
      prev_res   = results;
      if (in_valid && in_ready) exp_q.push_back(model(ins, scale, shift));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    for (int w = 0; w < N*CW/32; w++) ins[w*32 +: 32] = $urandom();
    scale = SW'($urandom());
    shift = SHW'($urandom());
  endtask

  // One beat through an empty pipeline with out_ready high; optional clr on its transfer cycle.
  task automatic send_one(input string nm, input logic [CW-1:0] iv, input logic [SW-1:0] sc,
                          input logic [SHW-1:0] sh, input logic [AW-1:0] ev, input logic es,
                          input bit clr);
    ins = rep_ins(iv); scale = sc; shift = sh; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; scale = ~sc; shift = ~sh;
    chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({nm, "_lat2"}, 32'(out_valid), 32'd1);
    chk_res({nm, "_value"}, results, rep_res(ev));
    chk({nm, "_sat"}, 32'(sat_any), 32'(es));
    clr_sat = clr;
    step();
    clr_sat = 1'b0;
  endtask

  // Two beats parked in S1/S2 with out_ready low.
  task automatic fill_stalled(input logic [CW-1:0] i1, input logic [SW-1:0] s1, input logic [SHW-1:0] h1,
                              input logic [CW-1:0] i2, input logic [SW-1:0] s2, input logic [SHW-1:0] h2);
    out_ready = 1'b0;
    ins = rep_ins(i1); scale = s1; shift = h1; in_valid = 1'b1;
    step();
    ins = rep_ins(i2); scale = s2; shift = h2;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int drained;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_res("rst_results", results, '0);
    chk("rst_sat_any", 32'(sat_any), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_first", 32'(in_ready), 32'd1);
    step();

    send_one("basic",   4'h3, 8'd5,   4'd2, 16'h003C, 1'b0, 1'b0);
    send_one("corner1", 4'h8, 8'h7F,  4'd5, 16'h8100, 1'b0, 1'b0);
    send_one("corner2", 4'h8, 8'h7F,  4'd6, 16'h8000, 1'b1, 1'b0);
    send_one("corner3", 4'h7, 8'h7F,  4'd6, 16'h7FFF, 1'b1, 1'b0);
    send_one("corner4", 4'h8, 8'h80,  4'd5, 16'h7FFF, 1'b1, 1'b0);
    chk("satcnt_three", 32'(sat_count), 32'd3);
    send_one("clr_race", 4'h7, 8'h7F, 4'd6, 16'h7FFF, 1'b1, 1'b1);
    chk("satcnt_clr_wins", 32'(sat_count), 32'd0);

    // Stall hold: 1*2<<1 = 4 and -1*3<<3 = -24 must survive scale/shift churn.
    fill_stalled(4'h1, 8'd2, 4'd1, 4'hF, 8'd3, 4'd3);
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      scale = SW'($urandom()); shift = SHW'($urandom());
      step();
    end
    chk_res("stall_b1", results, rep_res(16'h0004));
    out_ready = 1'b1;
    step();
    chk("stall_b2_valid", 32'(out_valid), 32'd1);
    chk_res("stall_b2", results, rep_res(16'hFFE8));
    step();
    chk("stall_empty", 32'(out_valid), 32'd0);

    sent = 0;
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      rand_payload();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
    end
    chk("stream_sent", 32'(sent), 32'd100);
    in_valid = 1'b0; out_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 20 && !drained; c++) begin
      step();
      if (exp_q.size() == 0 && !out_valid) drained = 1;
    end
    chk("stream_drained", 32'(drained), 32'd1);

    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      rand_payload();
      @(negedge clk);
      chk("thr_in_ready", 32'(in_ready), 32'd1);
      if (c >= 2) chk("thr_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();

    // Mid-stream asynchronous reset with both stages occupied.
    send_one("pre_rst", 4'h7, 8'h7F, 4'd6, 16'h7FFF, 1'b1, 1'b0);
    fill_stalled(4'h7, 8'h7F, 4'd6, 4'h8, 8'h7F, 4'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_sat_count", 32'(sat_count), 32'd0);
    chk("mrst_sat_any", 32'(sat_any), 32'd0);
    chk_res("mrst_results", results, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("mrst_no_stale", 32'(out_valid), 32'd0);
      step();
    end
    send_one("post_rst", 4'h3, 8'd5, 4'd2, 16'h003C, 1'b0, 1'b0);

    // Drive past 65535 saturating transfers; the counter must pin at all-ones.
    ins = rep_ins(4'h7); scale = 8'h7F; shift = 4'd6;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 65540; c++) step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("satcnt_sticky", 32'(sat_count), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dequantizer_array.md
DEQUANTIZER_ARRAY -- requirements
Module: dequantizer_array

Interface
REQ-001 The block SHALL have these parameters:
- DEQUANT_SIZE, default 64, number of lanes.
- COMPUTE_DATA_WIDTH, default 4, signed input lane width.
- ACCUMULATOR_DATA_WIDTH, default 16, signed output lane width.
- SCALE_WIDTH, default 8, signed scale width.
- SHIFT_WIDTH, default 4, unsigned left-shift amount width.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- ins  in  signed [COMPUTE_DATA_WIDTH] x DEQUANT_SIZE  quantized lanes.
- scale  in  signed SCALE_WIDTH  per-beat multiplier, sampled with ins.
- shift  in  SHIFT_WIDTH  per-beat left shift, sampled with ins.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- results  out  signed [ACCUMULATOR_DATA_WIDTH] x DEQUANT_SIZE  dequantized lanes.
- sat_any  out  1  at least one lane of the current output beat saturated.
- clr_sat  in  1  synchronous clear of sat_count.
- sat_count  out  16  number of transferred output beats with sat_any=1.
REQ-003 The block SHALL use one clock (clk) with asynchronous active-low reset rst_n and no other clock or reset.

Function
REQ-004 The block SHALL be a two-stage registered pipeline. S1 SHALL hold the lane products plus the captured shift. S2 SHALL hold the saturated results plus sat_any.
REQ-005 Each lane SHALL compute product = sign-extended ins[i] * scale. The product SHALL be signed and exactly COMPUTE_DATA_WIDTH+SCALE_WIDTH bits wide, with no truncation.
REQ-006 In S1->S2 the block SHALL form product <<< shift at a width that loses no bits, i.e. product width plus 2^SHIFT_WIDTH-1.
REQ-007 The block SHALL saturate that value to [-2^(ACCUMULATOR_DATA_WIDTH-1), 2^(ACCUMULATOR_DATA_WIDTH-1)-1]. A lane that clamps SHALL contribute to sat_any.
REQ-008 The registered stage valids SHALL update as follows:
- S2 accepts from S1 when S1 is valid and (!s2_valid || out_ready).
- S1 accepts from input when in_valid && in_ready.
REQ-009 in_ready SHALL equal !s1_valid || !s2_valid || out_ready. This gives full throughput: one beat per cycle with out_ready held high.
REQ-010 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when no backpressure is applied.
REQ-011 While out_valid && !out_ready, results and sat_any SHALL hold stable and out_valid SHALL stay high.
REQ-012 Beats SHALL never be dropped, duplicated or reordered, including under arbitrary out_ready toggling.
REQ-013 out_valid SHALL equal s2_valid, and results/sat_any SHALL be driven directly from S2 registers.
REQ-014 sat_count SHALL increment by 1 on each cycle where out_valid && out_ready && sat_any.
REQ-015 sat_count SHALL stick at 16'hFFFF and not wrap.
REQ-016 When clr_sat is asserted, sat_count SHALL become 0 on the next edge. If clr_sat and an increment event occur in the same cycle, clear SHALL win and the result SHALL be 0.
REQ-017 scale and shift SHALL be sampled only on input acceptance. Changes while the pipeline is stalled SHALL NOT affect in-flight beats.

Reset
REQ-018 Asserting rst_n low SHALL immediately and asynchronously force the following, regardless of clk:
- s1_valid=0, s2_valid=0, out_valid=0
- results all 0, sat_any=0, sat_count=0
REQ-019 After deassertion, in_ready SHALL be 1 in the first cycle.
REQ-020 Reset mid-operation SHALL discard all in-flight beats. No stale beat SHALL appear on out_valid after reset releases.

Verification
REQ-021 Single beat, ins all 3, scale=5, shift=2, out_ready=1 -> out_valid exactly 2 cycles after acceptance; all results=60; sat_any=0.
REQ-022 Saturation corners:
- ins=-8, scale=127, shift=5 -> -32512, no saturation.
- ins=-8, scale=127, shift=6 -> -32768, saturated.
- ins=7, scale=127, shift=6 -> 32767, saturated.
- ins=-8, scale=-128, shift=5 -> 32767, saturated.
REQ-023 Streaming 100 beats with random out_ready (50%) and random in_valid -> scoreboard matches the reference model in order with no loss. While stalled, results stay stable. With out_ready=1 and in_valid=1, throughput is 1 beat/cycle.
REQ-024 sat_count tests:
- 3 saturating beats transferred -> 3.
- clr_sat asserted on the same cycle as a 4th saturating transfer -> 0.
- Preload past 65535 events -> holds 16'hFFFF.
REQ-025 Stall hold: scale and shift change while 2 beats are stalled in the pipeline -> both beats emerge with their originally sampled scale/shift.
REQ-026 Mid-stream reset: rst_n asserted low asynchronously between clock edges with S1 and S2 full -> out_valid=0 and sat_count=0 immediately. After release, no output appears until a new input beat plus 2 cycles.
